// File: rtl/icache_arbiter.sv
// rtl/icache_arbiter.sv - two-requester read arbiter for the instruction cache port
//
// Ports:
//   clk, reset (async, active-low)
//   fetch_req/fetch_addr -> fetch_gnt; fetch_rvalid/fetch_rdata  high-priority fetch requester
//   dbg_req/dbg_addr     -> dbg_gnt;   dbg_rvalid/dbg_rdata      low-priority debug/loader requester
//   mem_r_en/mem_addr -> cache; mem_data <- cache (one cycle after mem_r_en)
//   starve_cnt: consecutive debug losses
module icache_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [3:0]        starve_cnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              iss_vld_q, iss_vld_d;
  logic              iss_dbg_q, iss_dbg_d;
  logic              fetch_rvalid_q, fetch_rvalid_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0] fetch_rdata_q, fetch_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              starved;
  logic              fetch_win;
  logic              dbg_win;

  always_comb begin
    // Debug only overrides fetch once it has lost STARVE_MAX times in a row.
    starved   = dbg_req && (starve_q == STARVE_LIM);
    fetch_win = fetch_req && !starved;
    dbg_win   = dbg_req && !fetch_win;

    // Grants and the cache address are forced low while reset is asserted.
    fetch_gnt = reset && fetch_win;
    dbg_gnt   = reset && dbg_win;
    mem_r_en  = fetch_gnt || dbg_gnt;

    if (!reset) begin
      mem_addr = '0;
    end else if (fetch_gnt) begin
      mem_addr = fetch_addr;
    end else if (dbg_gnt) begin
      mem_addr = dbg_addr;
    end else begin
      mem_addr = addr_q;
    end
    addr_d = mem_addr;

    starve_d = starve_q;
    if (dbg_gnt) begin
      starve_d = '0;
    end else if (fetch_gnt && dbg_req && (starve_q < STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end

    // Issue stage remembers who owns the word the cache returns next cycle.
    iss_vld_d = mem_r_en;
    iss_dbg_d = dbg_gnt;

    // Return stage: only the owner's rdata register is loaded.
    fetch_rvalid_d = iss_vld_q && !iss_dbg_q;
    dbg_rvalid_d   = iss_vld_q && iss_dbg_q;
    fetch_rdata_d  = fetch_rvalid_d ? mem_data : fetch_rdata_q;
    dbg_rdata_d    = dbg_rvalid_d   ? mem_data : dbg_rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q       <= '0;
      addr_q         <= '0;
      iss_vld_q      <= 1'b0;
      iss_dbg_q      <= 1'b0;
      fetch_rvalid_q <= 1'b0;
      dbg_rvalid_q   <= 1'b0;
      fetch_rdata_q  <= '0;
      dbg_rdata_q    <= '0;
    end else begin
      starve_q       <= starve_d;
      addr_q         <= addr_d;
      iss_vld_q      <= iss_vld_d;
      iss_dbg_q      <= iss_dbg_d;
      fetch_rvalid_q <= fetch_rvalid_d;
      dbg_rvalid_q   <= dbg_rvalid_d;
      fetch_rdata_q  <= fetch_rdata_d;
      dbg_rdata_q    <= dbg_rdata_d;
    end
  end

  assign fetch_rvalid = fetch_rvalid_q;
  assign dbg_rvalid   = dbg_rvalid_q;
  assign fetch_rdata  = fetch_rdata_q;
  assign dbg_rdata    = dbg_rdata_q;
  assign starve_cnt   = starve_q;

endmodule

// File: doc/icache_arbiter.md
Name: icache_arbiter

Overview:
- Shares the single read port of the instruction cache between two requesters: the core fetch unit (high priority) and the debug/loader read port (low priority).
- Issues at most one read per cycle and routes each returned word back to the requester that issued it.
- Bounds debug starvation with a consecutive-loss counter.
- Sits between the fetch stage and the instruction cache. The cache drives one-cycle registered read data.

Parameters:
- ADDR_W, 16, request/memory address width.
- DATA_W, 16, instruction word width.
- STARVE_MAX, 4, consecutive debug losses before debug is forced to win; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- fetch_req  input  1  fetch read request; held until granted.
- fetch_addr  input  ADDR_W  fetch address; stable while fetch_req is high.
- fetch_gnt  output  1  fetch request accepted this cycle.
- fetch_rvalid  output  1  fetch_rdata valid; one-cycle pulse.
- fetch_rdata  output  DATA_W  returned fetch word.
- dbg_req  input  1  debug read request; held until granted.
- dbg_addr  input  ADDR_W  debug address.
- dbg_gnt  output  1  debug request accepted this cycle.
- dbg_rvalid  output  1  dbg_rdata valid; one-cycle pulse.
- dbg_rdata  output  DATA_W  returned debug word.
- mem_r_en  output  1  cache read enable.
- mem_addr  output  ADDR_W  cache address.
- mem_data  input  DATA_W  cache read data, valid the cycle after mem_r_en.
- starve_cnt  output  4  current debug loss count, for observability.

Behaviour:
- Reset is asynchronous, active-low, and dominates every other event. While reset=0:
  - fetch_gnt, dbg_gnt, mem_r_en = 0 and mem_addr = 0 (forced combinationally).
  - fetch_rvalid, dbg_rvalid = 0; fetch_rdata, dbg_rdata = 0; starve_cnt = 0.
  - Issue and return pipeline stages are cleared.
- Arbitration is combinational, in the same cycle as the request:
  - Only fetch_req: fetch_gnt=1.
  - Only dbg_req: dbg_gnt=1.
  - Both requests: fetch wins unless starve_cnt == STARVE_MAX, in which case debug wins.
  - Neither request: no grant and mem_r_en=0.
  - At most one gnt is high in any cycle.
- A grant drives mem_r_en=1 and mem_addr = the winner's address in the same cycle. With no grant, mem_addr holds its previous value.
- Starvation counter, updated at the clock edge:
  - +1 when both requests are present and fetch wins.
  - Cleared to 0 when debug is granted.
  - Holds otherwise, including when dbg_req is absent.
  - Saturates at STARVE_MAX.
- Issue stage register: on a grant cycle N, owner (FETCH or DBG) and a valid bit are captured.
- Return stage, cycle N+1: mem_data is registered into the owner's rdata register only. The other requester's rdata holds.
- Cycle N+2: the owner's rvalid=1 for exactly one cycle.
- Total latency is gnt to rvalid = 2 cycles. Throughput is one read per cycle. Back-to-back grants produce back-to-back rvalid pulses in grant order.
- Responses are always delivered; there is no backpressure. Requesters must accept rdata when rvalid is high.
- Reset asserted mid-flight: in-flight reads are discarded and no rvalid appears after reset is released.
- Releasing a request in the same cycle it is granted is legal. Dropping a request before it is granted is legal: no grant is issued and no side effects occur.
- Address width: mem_addr passes ADDR_W bits unmodified. Range checking is the cache's responsibility.

Test Plan:
- Reset: hold reset=0 with both reqs high -> all gnt, rvalid, rdata and starve_cnt are 0; mem_r_en=0.
- Single fetch: memory model returns data=addr; fetch_req with addr 0x0005 in cycle N -> fetch_gnt=1 and mem_addr=0x0005 in N; fetch_rvalid=1 with fetch_rdata=0x0005 in N+2; dbg_rvalid stays 0.
- Streaming: fetch addresses 0x10, 0x11, 0x12 on consecutive cycles -> three consecutive fetch_rvalid pulses with data 0x10, 0x11, 0x12.
- Contention: both reqs held continuously, STARVE_MAX=4 -> fetch granted for 4 cycles (starve_cnt 1..4), debug granted on the 5th, starve_cnt returns to 0, and the pattern repeats.
- Interleave routing: debug addr 0x20 granted in N, fetch addr 0x21 granted in N+1 -> dbg_rvalid with 0x20 in N+2, fetch_rvalid with 0x21 in N+3; each rdata holds its value afterwards.
- Mid-flight reset: grant fetch in N, assert reset in N+1 -> no fetch_rvalid after release; the first post-reset request returns correct data at gnt+2.
